playback_controller: RTL and testbench
======================================

// Module: playback_controller
//
// PURPOSE
//   Transport sequencer for the music-player Timer. It turns debounced user
//   commands (play/pause, stop, fast-forward, rewind) into the Timer's count
//   enable, signed adder step and reset. It generates the one-second tick.
//   It detects the start and end of the track from the Timer's BCD digits.
//   Sits between the button front-end and the Timer/display_timer pair.
//
// PARAMETERS
//   CLK_FREQ_HZ  50_000_000  clk cycles per playback second (tick period)
//   SEEK_STEP    8           seconds moved per tick while seeking (1..63)
//
// PORTS
//   clk          in   1  system clock
//   reset        in   1  async reset, active-low
//   play_pause   in   1  1-cycle pulse: toggle play/pause
//   stop         in   1  1-cycle pulse: stop and rewind to 0:00
//   ff           in   1  level: fast-forward while high
//   rw           in   1  level: rewind while high
//   track_len    in   10 track length in seconds, 0..599
//   seconds0     in   4  Timer BCD seconds LSD
//   seconds1     in   4  Timer BCD seconds MSD
//   minutes0     in   4  Timer BCD minutes
//   count        out  1  1-cycle Timer enable, one per tick
//   adder        out  9  signed step the Timer applies when count=1
//   timer_reset  out  1  1-cycle pulse that clears the Timer to 0:00
//   playing      out  1  high in PLAYING, SEEK_FWD and SEEK_BACK
//   at_end       out  1  high in END
//
// BEHAVIOUR
//   Reset (reset=0, any time):
//     state=STOPPED; prescaler=0.
//     Outputs: count=0, adder=+1, timer_reset=0, playing=0, at_end=0.
//   Elapsed time:
//     elapsed = minutes0*60 + seconds1*10 + seconds0 (10-bit, combinational).
//     remaining = track_len - elapsed, clamped at 0.
//   Prescaler:
//     Counts 0..CLK_FREQ_HZ-1 in PLAYING/SEEK_*. tick=1 on terminal count, then wraps.
//     Held (not cleared) in PAUSED, so a resume keeps the phase.
//     Cleared in STOPPED and END.
//   Command priority: stop > play_pause > ff/rw.
//     ff and rw both high are treated as neither.
//   States and transitions:
//     STOPPED : play_pause -> PLAYING.
//     PLAYING : stop -> STOPPED; play_pause -> PAUSED; ff -> SEEK_FWD; rw -> SEEK_BACK.
//     PAUSED  : play_pause -> PLAYING; stop -> STOPPED; ff and rw are ignored.
//     SEEK_FWD/SEEK_BACK : release of the key -> PLAYING; stop -> STOPPED;
//       play_pause -> PAUSED.
//     END     : play_pause -> PLAYING, with a timer_reset pulse.
//       stop -> STOPPED; ff and rw are ignored.
//   Entering STOPPED from any state pulses timer_reset for 1 cycle.
//   On each tick, registered, count=1 for exactly 1 cycle with adder valid in the same cycle:
//     PLAYING  : adder=+1. If remaining<=1 -> END after this pulse.
//     SEEK_FWD : adder=+min(SEEK_STEP, remaining). If remaining<=SEEK_STEP -> END.
//     SEEK_BACK: adder=-min(SEEK_STEP, elapsed). If elapsed=0, no count pulse.
//       Stays in SEEK_BACK at 0:00 until the key is released.
//   Latency: tick -> count/adder is 1 cycle. The Timer updates on the following edge.
//   Boundaries:
//     count is never issued with adder=0.
//     track_len=0: PLAYING goes to END on the first tick without a count pulse.
//     elapsed>=track_len on entering PLAYING (e.g. track_len lowered): END on the next tick.
//     A command in the same cycle as a tick: the tick is evaluated in the current state.
//       The command then takes effect. At most one count per tick.
//   Outside tick cycles: count=0; adder holds its last value.
//
// CONFIGURATION
//   AUTO_REPEAT_EN defined:
//     Reaching END instead pulses timer_reset and returns to PLAYING in the next cycle.
//     at_end pulses high for 1 cycle; the prescaler restarts from 0.
//   AUTO_REPEAT_EN undefined:
//     END is held until play_pause or stop; at_end stays high.
//
// TESTING  (CLK_FREQ_HZ=4, SEEK_STEP=8)
//   Reset low mid-PLAYING -> next cycle count=0, adder=+1, playing=0, STOPPED.
//   play_pause, track_len=100 -> count every 4 clks, adder=+1.
//     Timer reaches 0:03 after 3 ticks.
//   play_pause again at 0:03, wait 40 clks -> no count pulses.
//     Resume -> first count in <=4 clks.
//   ff held at 0:03, track_len=20 -> adder=+8, +8, then +1 (to 0:20).
//     at_end=1 and count stops.
//   rw held at 0:05 -> adder=-5 once, then no pulses while held.
//     Release -> adder=+1.
//   stop and play_pause in the same cycle while PAUSED -> STOPPED, timer_reset 1-cycle pulse.
//     With AUTO_REPEAT_EN, at 0:20 of 20 -> timer_reset pulse, playing remains 1.

Source files
------------

// File: rtl/playback_controller_if.sv
// Bundle between the button front-end / Timer and playback_controller.
// master : drives the user commands, track length and the Timer's BCD digits.
// slave  : the controller; drives the Timer controls and the status flags.
//   play_pause, stop : 1-cycle command pulses
//   ff, rw           : seek key levels
//   track_len        : track length in seconds (0..599)
//   seconds0/1       : Timer BCD seconds LSD/MSD
//   minutes0         : Timer BCD minutes
//   count, adder     : Timer enable and signed step
//   timer_reset      : Timer clear pulse
//   playing, at_end  : transport status
interface playback_controller_if;
  logic              play_pause;
  logic              stop;
  logic              ff;
  logic              rw;
  logic [9:0]        track_len;
  logic [3:0]        seconds0;
  logic [3:0]        seconds1;
  logic [3:0]        minutes0;
  logic              count;
  logic signed [8:0] adder;
  logic              timer_reset;
  logic              playing;
  logic              at_end;

  modport master (
    output play_pause, stop, ff, rw, track_len, seconds0, seconds1, minutes0,
    input  count, adder, timer_reset, playing, at_end
  );

  modport slave (
    input  play_pause, stop, ff, rw, track_len, seconds0, seconds1, minutes0,
    output count, adder, timer_reset, playing, at_end
  );
endinterface

// File: rtl/playback_controller.sv
// Transport sequencer for the music-player Timer. Turns play/pause, stop,
// fast-forward and rewind into the Timer's count enable, signed step and
// clear, generates the one-second tick and detects start/end of track from
// the Timer's BCD digits.
//
// Ports:
//   clk   : system clock
//   reset : asynchronous reset, active-low
//   bus   : playback_controller_if.slave (commands, Timer digits in;
//           count/adder/timer_reset/playing/at_end out)
//
// Optional feature: define AUTO_REPEAT_EN to make END restart the track
// instead of holding there.
module playback_controller #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned SEEK_STEP   = 8
) (
  input logic                  clk,
  input logic                  reset,
  playback_controller_if.slave bus
);

  localparam int unsigned PW        = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(CLK_FREQ_HZ - 1);
  localparam logic [9:0]    Step     = 10'(SEEK_STEP);

  typedef enum logic [2:0] {
    StStopped,
    StPlaying,
    StPaused,
    StSeekFwd,
    StSeekBack,
    StEnd
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic              count_q, count_d;
  logic signed [8:0] adder_q, adder_d;
  logic              timer_reset_q, timer_reset_d;

  logic [9:0] elapsed;
  logic [9:0] remaining;
  logic [9:0] step_fwd;
  logic [9:0] step_back;
  logic       fwd_key;
  logic       back_key;
  logic       running;
  logic       tick;

  assign elapsed   = 10'(bus.minutes0) * 10'd60 + 10'(bus.seconds1) * 10'd10
                   + 10'(bus.seconds0);
  assign remaining = (bus.track_len > elapsed) ? bus.track_len - elapsed : '0;
  assign step_fwd  = (remaining < Step) ? remaining : Step;
  assign step_back = (elapsed < Step) ? elapsed : Step;

  // Both seek keys held together cancel out.
  assign fwd_key  = bus.ff & ~bus.rw;
  assign back_key = bus.rw & ~bus.ff;

  assign running = (state_q == StPlaying) || (state_q == StSeekFwd) ||
                   (state_q == StSeekBack);
  assign tick    = running && (presc_q == PrescMax);

  // Prescaler holds in PAUSED so a resume keeps the second's phase.
  always_comb begin
    presc_d = presc_q;
    if (running) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end else if (state_q != StPaused) begin
      presc_d = '0;
    end
  end

  always_comb begin
    state_d       = state_q;
    count_d       = 1'b0;
    adder_d       = adder_q;
    timer_reset_d = 1'b0;

    // The tick is evaluated in the current state; commands below may then
    // override the next state.
    if (tick) begin
      case (state_q)
        StPlaying: begin
          if (remaining != '0) begin
            count_d = 1'b1;
            adder_d = 9'sd1;
          end
          if (remaining <= 10'd1) state_d = StEnd;
        end
        StSeekFwd: begin
          if (remaining != '0) begin
            count_d = 1'b1;
            adder_d = $signed(9'(step_fwd));
          end
          if (remaining <= Step) state_d = StEnd;
        end
        StSeekBack: begin
          if (elapsed != '0) begin
            count_d = 1'b1;
            adder_d = -$signed(9'(step_back));
          end
        end
        default: ;
      endcase
    end

    if (bus.stop) begin
      state_d       = StStopped;
      timer_reset_d = (state_q != StStopped);
    end else if (bus.play_pause) begin
      case (state_q)
        StStopped, StPaused:               state_d = StPlaying;
        StPlaying, StSeekFwd, StSeekBack:  state_d = StPaused;
        StEnd: begin
          state_d       = StPlaying;
          timer_reset_d = 1'b1;
        end
        default: ;
      endcase
    end else begin
      case (state_q)
        StPlaying: begin
          if (fwd_key)       state_d = StSeekFwd;
          else if (back_key) state_d = StSeekBack;
        end
        StSeekFwd:  if (!fwd_key)  state_d = StPlaying;
        StSeekBack: if (!back_key) state_d = StPlaying;
`ifdef AUTO_REPEAT_EN
        StEnd: begin
          state_d       = StPlaying;
          timer_reset_d = 1'b1;
        end
`else
        StEnd: ;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StStopped;
      presc_q       <= '0;
      count_q       <= 1'b0;
      adder_q       <= 9'sd1;
      timer_reset_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      count_q       <= count_d;
      adder_q       <= adder_d;
      timer_reset_q <= timer_reset_d;
    end
  end

  assign bus.count       = count_q;
  assign bus.adder       = adder_q;
  assign bus.timer_reset = timer_reset_q;
  assign bus.at_end      = (state_q == StEnd);
`ifdef AUTO_REPEAT_EN
  // END lasts a single cycle on the way back to PLAYING, so it still counts as playing.
  assign bus.playing     = running || (state_q == StEnd);
`else
  assign bus.playing     = running;
`endif

endmodule

// File: tb/tb_playback_controller.sv
module tb_playback_controller;

  localparam int F = 4;
  localparam int S = 8;

  localparam int M_STOP  = 0;
  localparam int M_PLAY  = 1;
  localparam int M_PAUSE = 2;
  localparam int M_FWD   = 3;
  localparam int M_BACK  = 4;
  localparam int M_END   = 5;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  playback_controller_if bus ();

  playback_controller #(
    .CLK_FREQ_HZ(F),
    .SEEK_STEP  (S)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timer plant: seconds counter driven by the DUT outputs, shown as BCD.
  int t_sec;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)               t_sec <= 0;
    else if (bus.timer_reset) t_sec <= 0;
    else if (bus.count)       t_sec <= t_sec + int'(bus.adder);
  end
  assign bus.minutes0 = 4'(t_sec / 60);
  assign bus.seconds1 = 4'((t_sec % 60) / 10);
  assign bus.seconds0 = 4'(t_sec % 10);

  // Reference model: transport mode, cycles into the current second, the
  // model's own Timer position and the pending Timer controls.
  int m_mode, m_phase, m_sec, m_adder;
  bit m_count, m_treset;

  task automatic model_reset();
    m_mode = M_STOP; m_phase = 0; m_sec = 0;
    m_adder = 1; m_count = 0; m_treset = 0;
  endtask

  task automatic model_edge();
    int  sec, rem, pulse, nmode;
    bit  moving, tick, fwd, back, tr;
    if (!rst_n) begin
      model_reset();
      return;
    end
    sec    = m_sec;
    rem    = (int'(bus.track_len) > sec) ? int'(bus.track_len) - sec : 0;
    fwd    = bus.ff && !bus.rw;
    back   = bus.rw && !bus.ff;
    moving = (m_mode == M_PLAY) || (m_mode == M_FWD) || (m_mode == M_BACK);
    tick   = moving && (m_phase == F - 1);
    pulse  = 0;
    nmode  = m_mode;
    tr     = 0;

    if (m_treset)     m_sec = 0;
    else if (m_count) m_sec = m_sec + m_adder;

    if (tick && m_mode == M_PLAY) begin
      pulse = (rem > 0) ? 1 : 0;
      if (rem <= 1) nmode = M_END;
    end
    if (tick && m_mode == M_FWD) begin
      pulse = (rem < S) ? rem : S;
      if (rem <= S) nmode = M_END;
    end
    if (tick && m_mode == M_BACK) pulse = -((sec < S) ? sec : S);

    if (bus.stop) begin
      tr    = (m_mode != M_STOP);
      nmode = M_STOP;
    end else if (bus.play_pause) begin
      if (m_mode == M_STOP || m_mode == M_PAUSE) nmode = M_PLAY;
      else if (m_mode == M_END) begin nmode = M_PLAY; tr = 1; end
      else nmode = M_PAUSE;
    end else if (m_mode == M_PLAY && fwd)   nmode = M_FWD;
    else if (m_mode == M_PLAY && back)      nmode = M_BACK;
    else if (m_mode == M_FWD && !fwd)       nmode = M_PLAY;
    else if (m_mode == M_BACK && !back)     nmode = M_PLAY;

    if (moving)                m_phase = tick ? 0 : m_phase + 1;
    else if (m_mode != M_PAUSE) m_phase = 0;

    m_count  = (pulse != 0);
    if (pulse != 0) m_adder = pulse;
    m_treset = tr;
    m_mode   = nmode;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic cmp_all();
    chk("count", 32'(bus.count), 32'(m_count));
    chk("adder", 32'(bus.adder), m_adder);
    chk("timer_reset", 32'(bus.timer_reset), 32'(m_treset));
    chk("playing", 32'(bus.playing),
        32'((m_mode == M_PLAY) || (m_mode == M_FWD) || (m_mode == M_BACK)));
    chk("at_end", 32'(bus.at_end), 32'(m_mode == M_END));
    chk("timer", t_sec, m_sec);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cmp_all();
  endtask

  task automatic press_pp();
    bus.play_pause = 1'b1;
    step();
    bus.play_pause = 1'b0;
  endtask

  task automatic press_stop();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
  endtask

  int q[$];
  int exp_ff[3];
  int n;
  bit found;

  initial begin
    checks = 0;
    failures = 0;
    exp_ff = '{8, 8, 1};
    rst_n = 1'b0;
    bus.play_pause = 1'b0;
    bus.stop = 1'b0;
    bus.ff = 1'b0;
    bus.rw = 1'b0;
    bus.track_len = 10'd100;
    model_reset();

    // Reset state
    repeat (2) step();
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_adder", 32'(bus.adder), 1);
    chk("rst_playing", 32'(bus.playing), 0);
    chk("rst_at_end", 32'(bus.at_end), 0);
    rst_n = 1'b1;
    step();

    // Normal playback: three ticks bring the Timer to 0:03
    press_pp();
    repeat (13) step();
    chk("play_0_03", t_sec, 3);

    // Pause holds, resume keeps the phase
    press_pp();
    n = 0;
    repeat (40) begin
      step();
      if (bus.count) n++;
    end
    chk("paused_no_count", n, 0);
    press_pp();
    n = 1;
    found = bus.count;
    while (!found && n < 6) begin
      step();
      n++;
      found = bus.count;
    end
    chk("resume_latency", 32'(found && n <= 4), 1);

    // Fast-forward from 0:03 into a 20 s track
    press_stop();
    press_pp();
    repeat (13) step();
    chk("ff_start", t_sec, 3);
    bus.track_len = 10'd20;
    bus.ff = 1'b1;
    q.delete();
    repeat (24) begin
      step();
      if (bus.count) q.push_back(int'(bus.adder));
    end
    chk("ff_pulses", q.size(), 3);
    for (int i = 0; i < q.size() && i < 3; i++) chk("ff_step", q[i], exp_ff[i]);
    chk("ff_at_end", 32'(bus.at_end), 1);
    chk("ff_final", t_sec, 20);
    bus.ff = 1'b0;
    repeat (3) step();

    // Rewind from 0:05 clamps at 0:00
    press_stop();
    bus.track_len = 10'd100;
    press_pp();
    repeat (21) step();
    chk("rw_start", t_sec, 5);
    bus.rw = 1'b1;
    q.delete();
    repeat (30) begin
      step();
      if (bus.count) q.push_back(int'(bus.adder));
    end
    chk("rw_pulses", q.size(), 1);
    if (q.size() > 0) chk("rw_step", q[0], -5);
    bus.rw = 1'b0;
    n = 0;
    found = 0;
    while (!found && n < 8) begin
      step();
      n++;
      found = bus.count;
    end
    chk("rw_release_found", 32'(found), 1);
    chk("rw_release_adder", 32'(bus.adder), 1);

    // Stop beats play_pause while paused
    press_pp();
    bus.stop = 1'b1;
    bus.play_pause = 1'b1;
    step();
    bus.stop = 1'b0;
    bus.play_pause = 1'b0;
    chk("stop_pp_treset", 32'(bus.timer_reset), 1);
    chk("stop_pp_playing", 32'(bus.playing), 0);
    step();
    chk("stop_pp_treset_end", 32'(bus.timer_reset), 0);

    // Asynchronous reset in the middle of playback
    press_pp();
    repeat (6) step();
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("arst_count", 32'(bus.count), 0);
    chk("arst_adder", 32'(bus.adder), 1);
    chk("arst_playing", 32'(bus.playing), 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Zero-length track: END on the first tick with no count
    bus.track_len = 10'd0;
    press_pp();
    n = 0;
    repeat (10) begin
      step();
      if (bus.count) n++;
    end
    chk("len0_no_count", n, 0);
    chk("len0_at_end", 32'(bus.at_end), 1);
    press_stop();

    // Random command traffic against the model
    bus.track_len = 10'd60;
    for (int i = 0; i < 1500; i++) begin
      bus.play_pause = ($urandom_range(0, 15) == 0);
      bus.stop       = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 11) == 0) bus.ff = ~bus.ff;
      if ($urandom_range(0, 11) == 0) bus.rw = ~bus.rw;
      if ($urandom_range(0, 199) == 0) bus.track_len = 10'($urandom_range(0, 150));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
